perf_counter_sampler: RTL and testbench

Periodic snapshot engine sitting directly downstream of the performance counter's control slave. Acting as an Avalon-MM read master on that slave, it reads one counter section on a programmable period: 64-bit time counter (tear-free) plus 32-bit event count. Each sample goes into a small FIFO. The Nios II drains the FIFO through the block's own Avalon-MM slave, giving timestamped profiling traces without CPU polling.

---
 rtl/perf_sampler_pkg.sv | 26 ++
 rtl/perf_counter_sampler_if.sv | 19 +
 rtl/perf_sample_fifo.sv | 57 +++++
 rtl/perf_counter_sampler.sv | 176 +++++++++++++++++
 tb/tb_perf_counter_sampler.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/perf_sampler_pkg.sv
// Shared types and constants for the perf counter sampler.
// Register offsets, counter sub-offsets, FSM states, sample layout.
package perf_sampler_pkg;

  localparam logic [2:0] REG_CTRL    = 3'd0;
  localparam logic [2:0] REG_PERIOD  = 3'd1;
  localparam logic [2:0] REG_HEAD_LO = 3'd2;
  localparam logic [2:0] REG_HEAD_HI = 3'd3;
  localparam logic [2:0] REG_HEAD_EV = 3'd4;
  localparam logic [2:0] REG_POP     = 3'd5;

  localparam logic [2:0] TIME_LO = 3'd0;
  localparam logic [2:0] TIME_HI = 3'd1;
  localparam logic [2:0] EVENTS  = 3'd2;

  typedef enum logic [2:0] {
    IDLE, HI0, LO, HI1, EV, CHK, FIX, PUSH
  } state_t;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] events;
  } sample_t;

endpackage

// File: rtl/perf_counter_sampler_if.sv
// Avalon-MM style bus: 3-bit address, 32-bit data.
// master drives address/read/write/writedata; slave drives readdata.
interface perf_counter_sampler_if;
  logic [2:0]  address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, read, write, writedata,
    input  readdata
  );

  modport slave (
    input  address, read, write, writedata,
    output readdata
  );
endinterface

// File: rtl/perf_sample_fifo.sv
// Synchronous first-word-fall-through FIFO with flush.
// Ports: push/pop/flush in, wdata in, rdata/full/empty/count out.
module perf_sample_fifo #(
  parameter int W     = 96,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  input  logic [W-1:0]             wdata_i,
  output logic [W-1:0]             rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q;
  logic [AW-1:0] rd_q;
  logic [AW:0]   cnt_q;
  logic          do_push;
  logic          do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign count_o = cnt_q;
  assign rdata_o = mem_q[rd_q];

  // A pop frees the slot, so a push into a full FIFO
  // still lands when paired with a pop.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk) begin
    if (reset || flush_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      if (do_push && !do_pop)
        cnt_q <= cnt_q + 1'b1;
      else if (do_pop && !do_push)
        cnt_q <= cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= wdata_i;
  end

endmodule

// File: rtl/perf_counter_sampler.sv
// Periodic tear-free snapshot of one perf counter section into a FIFO.
// Ports: clk, reset, m (master to counter slave), s (CPU slave).
module perf_counter_sampler
  import perf_sampler_pkg::*;
#(
  parameter int          SECTION        = 0,
  parameter int          DEPTH          = 8,
  parameter logic [31:0] DEFAULT_PERIOD = 32'd999
) (
  input  logic                   clk,
  input  logic                   reset,
  perf_counter_sampler_if.master m,
  perf_counter_sampler_if.slave  s
);

  localparam logic [2:0] BASE = 3'(4 * SECTION);
  localparam int         CW   = $clog2(DEPTH) + 1;

  state_t        state_q;
  logic [2:0]    maddr_q;
  logic          mread_q;
  logic [31:0]   hi_q;
  logic [31:0]   lo_q;
  logic [31:0]   hi1_q;
  logic [31:0]   ev_q;

  logic          enable_q;
  logic          overflow_q;
  logic          missed_q;
  logic [31:0]   period_q;
  logic [31:0]   presc_q;
  logic [31:0]   presc_d;
  logic [31:0]   rdata_q;
  logic [31:0]   rdata_d;

  logic          ctrl_wr;
  logic          pop_wr;
  logic          clr;
  logic          tick;
  logic          push;
  sample_t       head;
  logic          full;
  logic          empty;
  logic [CW-1:0] fcount;

  assign m.address   = maddr_q;
  assign m.read      = mread_q;
  assign m.write     = 1'b0;
  assign m.writedata = '0;
  assign s.readdata  = rdata_q;

  assign ctrl_wr = s.write && (s.address == REG_CTRL);
  assign pop_wr  = s.write && (s.address == REG_POP);
  assign clr     = ctrl_wr && s.writedata[1];
  assign tick    = enable_q && (presc_q == '0);
  assign push    = (state_q == PUSH);

  perf_sample_fifo #(
    .W     ($bits(sample_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .pop_i   (pop_wr),
    .flush_i (clr),
    .wdata_i ({hi_q, lo_q, ev_q}),
    .rdata_o (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (fcount)
  );

  // Hi is read on both sides of lo; if it moved,
  // lo is re-read so it pairs with the newer hi.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      maddr_q <= BASE;
      mread_q <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      hi1_q   <= '0;
      ev_q    <= '0;
    end else begin
      unique case (state_q)
        IDLE: if (tick) begin
          state_q <= HI0;
          maddr_q <= BASE + TIME_HI;
          mread_q <= 1'b1;
        end
        HI0: begin
          state_q <= LO;
          maddr_q <= BASE + TIME_LO;
        end
        LO: begin
          hi_q    <= m.readdata;
          state_q <= HI1;
          maddr_q <= BASE + TIME_HI;
        end
        HI1: begin
          lo_q    <= m.readdata;
          state_q <= EV;
          maddr_q <= BASE + EVENTS;
        end
        EV: begin
          hi1_q   <= m.readdata;
          state_q <= CHK;
          maddr_q <= BASE + TIME_LO;
        end
        CHK: begin
          ev_q    <= m.readdata;
          mread_q <= 1'b0;
          maddr_q <= BASE;
          state_q <= (hi1_q == hi_q) ? PUSH : FIX;
        end
        FIX: begin
          lo_q    <= m.readdata;
          hi_q    <= hi1_q;
          state_q <= PUSH;
        end
        PUSH:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    presc_d = presc_q;
    if (ctrl_wr && s.writedata[0] && !enable_q)
      presc_d = period_q;
    else if (enable_q)
      presc_d = (presc_q == '0) ? period_q
                                : presc_q - 1'b1;
  end

  always_comb begin
    rdata_d = '0;
    case (s.address)
      REG_CTRL:    rdata_d = {16'h0, 8'(fcount), 5'h0,
                              missed_q, overflow_q,
                              enable_q};
      REG_PERIOD:  rdata_d = period_q;
      REG_HEAD_LO: rdata_d = empty ? '0 : head.lo;
      REG_HEAD_HI: rdata_d = empty ? '0 : head.hi;
      REG_HEAD_EV: rdata_d = empty ? '0 : head.events;
      default:     rdata_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      enable_q   <= 1'b0;
      overflow_q <= 1'b0;
      missed_q   <= 1'b0;
      period_q   <= DEFAULT_PERIOD;
      presc_q    <= DEFAULT_PERIOD;
      rdata_q    <= '0;
    end else begin
      presc_q <= presc_d;
      if (s.read) rdata_q <= rdata_d;
      if (ctrl_wr) enable_q <= s.writedata[0];
      if (s.write && (s.address == REG_PERIOD))
        period_q <= s.writedata;
      if (clr)
        missed_q <= 1'b0;
      else if (tick && (state_q != IDLE))
        missed_q <= 1'b1;
      if (clr)
        overflow_q <= 1'b0;
      else if (push && full && !pop_wr)
        overflow_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_perf_counter_sampler.sv
// Scoreboard bench for perf_counter_sampler with a counter slave model.
// Reads push expected data; a monitor pops and compares s.readdata.
module tb_perf_counter_sampler;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  perf_counter_sampler_if m_bus ();
  perf_counter_sampler_if s_bus ();

  perf_counter_sampler #(
    .SECTION        (0),
    .DEPTH          (8),
    .DEFAULT_PERIOD (32'd999)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .m     (m_bus),
    .s     (s_bus)
  );

  logic [63:0] time_v = 64'h0;
  logic [31:0] ev_v   = 32'h0;

  always @(posedge clk) begin
    if (reset)
      m_bus.readdata <= 32'h0;
    else if (m_bus.read)
      case (m_bus.address)
        3'd0:    m_bus.readdata <= time_v[31:0];
        3'd1:    m_bus.readdata <= time_v[63:32];
        3'd2:    m_bus.readdata <= ev_v;
        default: m_bus.readdata <= 32'h0;
      endcase
  end

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];
  string       name_q[$];
  logic        rd_pend = 1'b0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h want 0x%08h",
               nm, act, exp);
    end
  endtask

  always @(posedge clk) rd_pend <= s_bus.read;

  always @(negedge clk) begin
    if (rd_pend) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL rd_unexpected: got 0x%08h want none",
                 s_bus.readdata);
      end else begin
        chk(name_q.pop_front(), s_bus.readdata,
            exp_q.pop_front());
      end
    end
  end

  task automatic rd(input logic [2:0] a,
                    input logic [31:0] e,
                    input string nm);
    s_bus.address = a;
    s_bus.read    = 1'b1;
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(negedge clk);
    s_bus.read = 1'b0;
  endtask

  task automatic wr(input logic [2:0] a,
                    input logic [31:0] d);
    s_bus.address   = a;
    s_bus.writedata = d;
    s_bus.write     = 1'b1;
    @(negedge clk);
    s_bus.write = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen;
    s_bus.address   = 3'd0;
    s_bus.read      = 1'b0;
    s_bus.write     = 1'b0;
    s_bus.writedata = 32'h0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst_mread", 32'(m_bus.read), 32'h0);
    chk("rst_maddr", 32'(m_bus.address), 32'h0);
    chk("rst_sread", s_bus.readdata, 32'h0);

    // reset register state
    rd(3'd0, 32'h0, "rst_ctrl");
    rd(3'd1, 32'd999, "rst_period");
    rd(3'd2, 32'h0, "rst_head_lo");
    rd(3'd3, 32'h0, "rst_head_hi");
    rd(3'd4, 32'h0, "rst_head_ev");
    rd(3'd5, 32'h0, "rst_pop");
    rd(3'd6, 32'h0, "rst_reg6");

    // basic sample, PERIOD=20, PUSH exactly 6 after tick
    time_v = 64'h0000_0003_FFFF_FFF0;
    ev_v   = 32'd5;
    wr(3'd1, 32'd20);
    rd(3'd1, 32'd20, "period_rb");
    wr(3'd0, 32'h1);
    repeat (26) @(negedge clk);
    rd(3'd0, 32'h0000_0001, "s1_not_yet");
    rd(3'd0, 32'h0000_0101, "s1_ctrl");
    rd(3'd2, 32'hFFFF_FFF0, "s1_lo");
    rd(3'd3, 32'h0000_0003, "s1_hi");
    rd(3'd4, 32'd5, "s1_ev");
    wr(3'd0, 32'h0);
    wr(3'd5, 32'h0);
    rd(3'd0, 32'h0, "s1_popped");

    // hi word changes between the two hi reads
    time_v = 64'h0000_0003_FFFF_FFFF;
    ev_v   = 32'd9;
    wr(3'd0, 32'h1);
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (m_bus.read && m_bus.address == 3'd0)
        seen = 1'b1;
    end
    chk("wrap_lo_seen", 32'(seen), 32'h1);
    @(negedge clk);
    time_v = 64'h0000_0004_0000_0000;
    repeat (6) @(negedge clk);
    wr(3'd0, 32'h0);
    rd(3'd3, 32'h0000_0004, "fix_hi");
    rd(3'd2, 32'h0000_0000, "fix_lo");
    rd(3'd4, 32'd9, "fix_ev");
    rd(3'd0, 32'h0000_0100, "fix_ctrl");
    wr(3'd5, 32'h0);
    rd(3'd0, 32'h0, "fix_popped");

    // overflow: 9 samples into 8 entries
    wr(3'd1, 32'd7);
    wr(3'd0, 32'h1);
    repeat (74) @(negedge clk);
    wr(3'd0, 32'h0);
    repeat (6) @(negedge clk);
    rd(3'd0, 32'h0000_0802, "ovf_ctrl");
    rd(3'd3, 32'h0000_0004, "ovf_hi");
    repeat (4) wr(3'd5, 32'h0);
    rd(3'd0, 32'h0000_0402, "ovf_pop4");
    repeat (4) wr(3'd5, 32'h0);
    rd(3'd0, 32'h0000_0002, "ovf_pop8");
    rd(3'd2, 32'h0, "ovf_empty_lo");
    wr(3'd5, 32'h0);
    rd(3'd0, 32'h0000_0002, "ovf_pop_empty");
    wr(3'd0, 32'h2);
    rd(3'd0, 32'h0, "ovf_cleared");

    // missed tick with PERIOD=2, then clear keeps enable
    wr(3'd1, 32'd2);
    wr(3'd0, 32'h1);
    repeat (6) @(negedge clk);
    wr(3'd0, 32'h0);
    repeat (3) @(negedge clk);
    rd(3'd0, 32'h0000_0104, "miss_ctrl");
    wr(3'd0, 32'h1);
    wr(3'd0, 32'h3);
    rd(3'd0, 32'h0000_0001, "clr_ctrl");
    wr(3'd0, 32'h0);
    repeat (12) @(negedge clk);
    wr(3'd0, 32'h2);
    rd(3'd0, 32'h0, "clr_idle");

    // disable while in EV: sample completes, no more
    time_v = 64'h0000_0007_1234_5678;
    ev_v   = 32'h0000_ABCD;
    wr(3'd1, 32'd20);
    wr(3'd0, 32'h1);
    repeat (24) @(negedge clk);
    chk("ev_addr", 32'(m_bus.address), 32'h2);
    chk("ev_read", 32'(m_bus.read), 32'h1);
    wr(3'd0, 32'h0);
    repeat (100) @(negedge clk);
    rd(3'd0, 32'h0000_0100, "dis_ctrl");
    rd(3'd2, 32'h1234_5678, "dis_lo");
    rd(3'd3, 32'h0000_0007, "dis_hi");
    rd(3'd4, 32'h0000_ABCD, "dis_ev");

    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL sb_drain: got %0d pending want 0",
               exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
